// File: rtl/cdc_pulse_pacer_pkg.sv
// cdc_pulse_pacer_pkg: shared state encoding and gap-counter sizing for the
// cdc_pulse_pacer block and its gap timer.
package cdc_pulse_pacer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FIRE = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  // Ceiling log2. Sizes the gap down-counter so that it can hold GAP-1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << r) < 64'(v)) r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/cdc_pulse_pacer_if.sv
// cdc_pulse_pacer_if: event strobe in, paced strobe and status out.
// master = event producer / observer, slave = the pacer.
interface cdc_pulse_pacer_if #(
  parameter int unsigned CNT_W = 4
) ();
  logic             in_pulse;
  logic             flush;
  logic             ovf_clr;
  logic             out_pulse;
  logic [CNT_W-1:0] pending;
  logic             busy;
  logic             overflow;

  modport master (
    output in_pulse, flush, ovf_clr,
    input  out_pulse, pending, busy, overflow
  );

  modport slave (
    input  in_pulse, flush, ovf_clr,
    output out_pulse, pending, busy, overflow
  );
endinterface

// File: rtl/cdc_pulse_pacer_gap_timer.sv
// cdc_pulse_pacer_gap_timer: loadable down-counter timing the HOLD phase.
// Loaded with GAP-1 on entry to HOLD; expire marks the last HOLD cycle.
module cdc_pulse_pacer_gap_timer
  import cdc_pulse_pacer_pkg::*;
#(
  parameter int unsigned GAP = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic expire
);

  localparam int unsigned W = (clog2(GAP) < 1) ? 1 : clog2(GAP);
  localparam logic [W-1:0] RELOAD = W'(GAP - 1);

  logic [W-1:0] cnt;

  // Reload on entry to HOLD, then count down to zero and rest there.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= RELOAD;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign expire = (cnt == W'(1));

endmodule

// File: rtl/cdc_pulse_pacer.sv
// cdc_pulse_pacer: counts raw event strobes and re-emits them as isolated
// one-cycle pulses at least GAP cycles apart, ahead of an edge-toggle
// pulse synchronizer. Reports backlog depth and a sticky overflow flag.
// Build option CDC_PULSE_PACER_QUEUE_EN: full CNT_W-bit backlog counter;
// when undefined the backlog is a single flag and CNT_W sets port width only.
module cdc_pulse_pacer
  import cdc_pulse_pacer_pkg::*;
#(
  parameter int unsigned CNT_W = 4,
  parameter int unsigned GAP   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  cdc_pulse_pacer_if.slave   bus
);

`ifdef CDC_PULSE_PACER_QUEUE_EN
  localparam int unsigned PW = CNT_W;
`else
  localparam int unsigned PW = 1;
`endif
  localparam logic [PW-1:0] PMAX = '1;

  state_e        state_q, state_d;
  logic [PW-1:0] pend_q, pend_d;
  logic          out_q, busy_q, ovf_q;
  logic          want, fire, drop, expire;

  cdc_pulse_pacer_gap_timer #(.GAP(GAP)) u_gap_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (state_q == ST_FIRE),
    .expire (expire)
  );

  // Flush blocks any move into FIRE on its edge, from IDLE or from HOLD.
  assign want = (bus.in_pulse || (pend_q != '0)) && !bus.flush;

  // Next state and backlog accounting.
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    drop    = 1'b0;
    unique case (state_q)
      ST_IDLE: if (want) state_d = ST_FIRE;
      ST_FIRE: state_d = ST_HOLD;
      ST_HOLD: if (expire) state_d = want ? ST_FIRE : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    fire = (state_d == ST_FIRE);
    // A fire without a fresh strobe implies pend_q != 0, so no underflow.
    if (bus.flush) begin
      pend_d = '0;
    end else if (fire) begin
      if (!bus.in_pulse) pend_d = pend_q - PW'(1);
    end else if (bus.in_pulse) begin
      if (pend_q == PMAX) drop = 1'b1;
      else                pend_d = pend_q + PW'(1);
    end
  end

  // State, backlog and all outputs registered together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pend_q  <= '0;
      out_q   <= 1'b0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      out_q   <= fire;
      busy_q  <= (state_d != ST_IDLE) || (pend_d != '0);
      if (drop)             ovf_q <= 1'b1;
      else if (bus.ovf_clr) ovf_q <= 1'b0;
    end
  end

  assign bus.out_pulse = out_q;
  assign bus.pending   = CNT_W'(pend_q);
  assign bus.busy      = busy_q;
  assign bus.overflow  = ovf_q;

endmodule
